// File: rtl/mult_unit.sv
// mult_unit: iterative shift-add 32x32->64 multiplier for MULT/MULTU.
// Signed operands are reduced to magnitudes, then the product sign is fixed up once at the end.
module mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
    state_t             state_q;
    logic [WIDTH-1:0]   mcand_q, hi_q, lo_q, a_mag, b_mag;
    logic [2*WIDTH-1:0] prod_q, prod_d, res;
    logic [CW-1:0]      cnt_q;
    logic               neg_q, busy_q, done_q;
    logic [WIDTH:0]     sum;
    always_comb begin
        a_mag  = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
        b_mag  = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;
        // 33-bit add keeps the carry-out so unsigned max operands do not overflow
        sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? mcand_q : {WIDTH{1'b0}})};
        prod_d = {sum, prod_q[WIDTH-1:1]};
        res    = neg_q ? (~prod_q + 1'b1) : prod_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        mcand_q <= a_mag;
                        prod_q  <= {{WIDTH{1'b0}}, b_mag};
                        neg_q   <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    prod_q <= prod_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LAST) state_q <= FIX;
                end
                FIX: begin
                    {hi_q, lo_q} <= res;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b1;
                    state_q      <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule
